// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file types and constants for the writeback front end
package regfile_pkg;

  localparam int RF_BANKS    = 2;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_RD_PORTS = 6;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

  // r0 is hardwired; writes to it are accepted and thrown away
  function automatic logic is_drop(input logic [RF_ADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/wb_bank_queue.sv
// rtl/wb_bank_queue.sv - 2-push/1-pop circular pending-write queue for one register-file bank
module wb_bank_queue
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [1:0]                            push_valid,
  input  logic [1:0][RF_ADDR_W-1:0]             push_addr,
  input  logic [1:0][WIDTH-1:0]                 push_data,
  input  logic                                  pop,
  output logic [RF_ADDR_W-1:0]                  head_addr,
  output logic [WIDTH-1:0]                      head_data,
  output logic                                  empty,
  output logic [$clog2(DEPTH):0]                count,
  input  logic [RF_RD_PORTS-1:0][RF_ADDR_W-1:0] ra,
  output logic [RF_RD_PORTS-1:0]                hit
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RF_ADDR_W-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     wr_ptr1;
  logic [1:0]           n_push;
  logic [CNT_W:0]       count_wide;

  // push slots may arrive with a gap (slot 1 only); the second write lands right after the first
  assign n_push     = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
  assign wr_ptr1    = wr_ptr + PTR_W'(push_valid[0]);
  assign count_wide = {1'b0, count} + (CNT_W+1)'(n_push) - (CNT_W+1)'(pop);
  assign empty      = (count == '0);
  assign head_addr  = addr_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_valid[0]) begin
      addr_q[wr_ptr] <= push_addr[0];
      data_q[wr_ptr] <= push_data[0];
    end
    if (push_valid[1]) begin
      addr_q[wr_ptr1] <= push_addr[1];
      data_q[wr_ptr1] <= push_data[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      if (push_valid[0]) valid_q[wr_ptr]  <= 1'b1;
      if (push_valid[1]) valid_q[wr_ptr1] <= 1'b1;
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      count  <= count_wide[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (count_wide <= (CNT_W+1)'(DEPTH));
  end

  // the head is always popped when present, so it is already on its port and not pending
  always_comb begin
    hit = '0;
    for (int k = 0; k < RF_RD_PORTS; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && addr_q[i] == ra[k] && !(pop && PTR_W'(i) == rd_ptr)) hit[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - steers two writebacks per cycle onto bank-dedicated register-file write ports
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [1:0]                            req_valid_i,
  input  logic [1:0][RF_ADDR_W-1:0]             req_addr_i,
  input  logic [1:0][WIDTH-1:0]                 req_data_i,
  output logic                                  req_ready_o,
  output logic [RF_ADDR_W-1:0]                  wa0_o,
  output logic [RF_ADDR_W-1:0]                  wa1_o,
  output logic                                  we0_o,
  output logic                                  we1_o,
  output logic [WIDTH-1:0]                      wd0_o,
  output logic [WIDTH-1:0]                      wd1_o,
  input  logic [RF_RD_PORTS-1:0][RF_ADDR_W-1:0] ra_i,
  output logic [RF_RD_PORTS-1:0]                pend_o
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEPTH - 2);

  logic [1:0]                                   acc;
  logic [RF_BANKS-1:0]                          bank_room;
  logic [RF_BANKS-1:0]                          bank_we;
  logic [RF_BANKS-1:0][RF_ADDR_W-1:0]           bank_wa;
  logic [RF_BANKS-1:0][WIDTH-1:0]               bank_wd;
  logic [RF_BANKS-1:0][RF_RD_PORTS-1:0]         bank_pend;

  // two free slots per bank guarantee a worst-case same-bank pair always fits
  assign req_ready_o = rst_n && (&bank_room);

  always_comb begin
    acc = '0;
    for (int s = 0; s < 2; s++) acc[s] = req_valid_i[s] && req_ready_o && !is_drop(req_addr_i[s]);
  end

  for (genvar b = 0; b < RF_BANKS; b++) begin : g_bank
    logic [1:0]             tgt;
    logic [1:0]             push_valid;
    logic                   q_empty;
    logic [RF_ADDR_W-1:0]   head_addr;
    logic [WIDTH-1:0]       head_data;
    logic [CNT_W-1:0]       q_count;
    logic [RF_RD_PORTS-1:0] q_hit;
    logic [RF_RD_PORTS-1:0] slot_hit;

    assign tgt[0] = acc[0] && (req_addr_i[0][0] == 1'(b));
    assign tgt[1] = acc[1] && (req_addr_i[1][0] == 1'(b));

    // queued work drains first to keep program order; otherwise the oldest new slot bypasses
    assign push_valid    = !q_empty ? tgt : (tgt[0] ? {tgt[1], 1'b0} : 2'b00);
    assign bank_we[b]    = rst_n && (!q_empty || (|tgt));
    assign bank_wa[b]    = !q_empty ? head_addr : (tgt[0] ? req_addr_i[0] : req_addr_i[1]);
    assign bank_wd[b]    = !q_empty ? head_data : (tgt[0] ? req_data_i[0] : req_data_i[1]);
    assign bank_room[b]  = (q_count <= CNT_LIM);
    assign bank_pend[b]  = q_hit | slot_hit;

    always_comb begin
      slot_hit = '0;
      for (int k = 0; k < RF_RD_PORTS; k++) begin
        slot_hit[k] = (push_valid[0] && req_addr_i[0] == ra_i[k]) ||
                      (push_valid[1] && req_addr_i[1] == ra_i[k]);
      end
    end

    wb_bank_queue #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (push_valid),
      .push_addr  (req_addr_i),
      .push_data  (req_data_i),
      .pop        (!q_empty),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .empty      (q_empty),
      .count      (q_count),
      .ra         (ra_i),
      .hit        (q_hit)
    );
  end

  assign we0_o  = bank_we[0];
  assign we1_o  = bank_we[1];
  assign wa0_o  = bank_we[0] ? bank_wa[0] : RF_ADDR_W'(0);
  assign wa1_o  = bank_we[1] ? bank_wa[1] : RF_ADDR_W'(1);
  assign wd0_o  = bank_wd[0];
  assign wd1_o  = bank_wd[1];
  assign pend_o = rst_n ? (bank_pend[0] | bank_pend[1]) : '0;

endmodule
